// File: rtl/slowmem_cache_ctrl_pkg.sv
// ============================================================================
// Module      : slowmem_cache_ctrl_pkg
// Description : Shared types and constants for the slowmem cache controller.
//               It holds the word width, the controller state encoding, the
//               slowmem access delay, and the default post-reset drain length
//               derived from that delay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package slowmem_cache_ctrl_pkg;

    localparam int WORD          = 16;
    // slowmem read delay, in cycles from strobe to mfc
    localparam int MEMDELAY      = 4;
    // A stale read can still complete MEMDELAY+2 cycles after an abort.
    localparam int DRAIN_DEFAULT = MEMDELAY + 2;

    typedef logic [WORD-1:0] word_t;

    typedef enum logic [1:0] {
        ST_DRAIN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/slowmem_cache_ctrl_if.sv
// ============================================================================
// Module      : slowmem_cache_ctrl_if
// Description : Bundles the processor-side request bus and the slowmem
//               strobe/mfc bus.
//               master : controller view. It drives cpu_rdata, cpu_ready,
//                        cpu_err, cpu_busy and the mem_* request fields.
//               slave  : environment view. It drives the cpu request fields,
//                        mem_mfc and mem_rdata.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface slowmem_cache_ctrl_if;
    import slowmem_cache_ctrl_pkg::*;

    logic  cpu_req;
    logic  cpu_rnotw;
    word_t cpu_addr;
    word_t cpu_wdata;
    word_t cpu_rdata;
    logic  cpu_ready;
    logic  cpu_err;
    logic  cpu_busy;

    logic  mem_strobe;
    logic  mem_rnotw;
    word_t mem_addr;
    word_t mem_wdata;
    logic  mem_mfc;
    word_t mem_rdata;

    modport master (
        input  cpu_req, cpu_rnotw, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_err, cpu_busy,
        output mem_strobe, mem_rnotw, mem_addr, mem_wdata,
        input  mem_mfc, mem_rdata
    );

    modport slave (
        output cpu_req, cpu_rnotw, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_err, cpu_busy,
        input  mem_strobe, mem_rnotw, mem_addr, mem_wdata,
        output mem_mfc, mem_rdata
    );

endinterface

`default_nettype wire

// File: rtl/slowmem_cache_ctrl_cache_line_store.sv
// ============================================================================
// Module      : cache_line_store
// Description : Direct-mapped store with LINES one-word lines. Each line holds
//               a valid bit, a tag and a data word. Reset clears the valid bits
//               asynchronously.
// Ports       : clk, reset
//               rd_addr_i  -> hit_o, rd_data_o  combinational lookup
//               wr_en_i, wr_addr_i, wr_data_i   synchronous write that sets
//                                               valid and the tag and
//                                               replaces the data word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_line_store
    import slowmem_cache_ctrl_pkg::*;
#(
    parameter int IDX_BITS = 3
) (
    input  logic  clk,
    input  logic  reset,
    input  word_t rd_addr_i,
    output logic  hit_o,
    output word_t rd_data_o,
    input  logic  wr_en_i,
    input  word_t wr_addr_i,
    input  word_t wr_data_i
);

    localparam int LINES    = 1 << IDX_BITS;
    localparam int TAG_BITS = WORD - IDX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    word_t               data_q [LINES];

    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;

    assign rd_idx = rd_addr_i[IDX_BITS-1:0];
    assign wr_idx = wr_addr_i[IDX_BITS-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset because a cleared valid bit masks them.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx]  <= wr_addr_i[WORD-1:IDX_BITS];
            data_q[wr_idx] <= wr_data_i;
        end
    end

    assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_addr_i[WORD-1:IDX_BITS]);
    assign rd_data_o = data_q[rd_idx];

endmodule

`default_nettype wire

// File: rtl/slowmem_cache_ctrl.sv
// ============================================================================
// Module      : slowmem_cache_ctrl
// Description : Processor-side slowmem initiator with a direct-mapped,
//               write-through, no-write-allocate cache. A read hit completes
//               in 1 cycle. A write completes in 1 cycle and issues a slowmem
//               write strobe in the same cycle. A read miss issues one slowmem
//               read strobe and waits for mfc. If mfc does not arrive within
//               TIMEOUT cycles, the read aborts and reports an error.
// Ports       : clk, reset (asynchronous, active high)
//               bus_io : processor request bus and slowmem bus (master view)
//               hit_count_o, miss_count_o, timeout_count_o : saturating read
//                 statistics. These exist only when SLOWMEM_CACHE_STATS_EN
//                 is defined.
// Options     : SLOWMEM_CACHE_STATS_EN enables the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slowmem_cache_ctrl
    import slowmem_cache_ctrl_pkg::*;
#(
    parameter int IDX_BITS = 3,
    parameter int TIMEOUT  = 32,
    parameter int DRAIN    = DRAIN_DEFAULT
) (
    input  logic clk,
    input  logic reset,
`ifdef SLOWMEM_CACHE_STATS_EN
    output logic [15:0] hit_count_o,
    output logic [15:0] miss_count_o,
    output logic [15:0] timeout_count_o,
`endif
    slowmem_cache_ctrl_if.master bus_io
);

    localparam int CNT_MAX = (TIMEOUT > DRAIN) ? TIMEOUT : DRAIN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             ready_q,  ready_d;
    logic             err_q,    err_d;
    word_t            rdata_q,  rdata_d;
    logic             strobe_q, strobe_d;
    logic             mrnotw_q, mrnotw_d;
    word_t            maddr_q,  maddr_d;
    word_t            mwdata_q, mwdata_d;
    logic             busy_q,   busy_d;

    logic  lookup_hit;
    word_t lookup_data;
    logic  store_wr_en;
    word_t store_wr_addr;
    word_t store_wr_data;

    cache_line_store #(
        .IDX_BITS (IDX_BITS)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_i (bus_io.cpu_addr),
        .hit_o     (lookup_hit),
        .rd_data_o (lookup_data),
        .wr_en_i   (store_wr_en),
        .wr_addr_i (store_wr_addr),
        .wr_data_i (store_wr_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_DRAIN;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            strobe_q <= 1'b0;
            mrnotw_q <= 1'b1;
            maddr_q  <= '0;
            mwdata_q <= '0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            strobe_q <= strobe_d;
            mrnotw_q <= mrnotw_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ready_d       = 1'b0;
        err_d         = 1'b0;
        rdata_d       = rdata_q;
        strobe_d      = 1'b0;
        mrnotw_d      = mrnotw_q;
        maddr_d       = maddr_q;
        mwdata_d      = mwdata_q;
        store_wr_en   = 1'b0;
        store_wr_addr = bus_io.cpu_addr;
        store_wr_data = bus_io.cpu_wdata;

        case (state_q)
            ST_DRAIN: begin
                // mfc is ignored here so that a late response from an aborted
                // read cannot complete anything.
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_IDLE: begin
                if (bus_io.cpu_req) begin
                    if (bus_io.cpu_rnotw) begin
                        if (lookup_hit) begin
                            ready_d = 1'b1;
                            rdata_d = lookup_data;
                        end else begin
                            strobe_d = 1'b1;
                            mrnotw_d = 1'b1;
                            maddr_d  = bus_io.cpu_addr;
                            state_d  = ST_ISSUE;
                        end
                    end else begin
                        // Write-through: always go to slowmem. Refresh the
                        // line only when it already holds this address.
                        strobe_d    = 1'b1;
                        mrnotw_d    = 1'b0;
                        maddr_d     = bus_io.cpu_addr;
                        mwdata_d    = bus_io.cpu_wdata;
                        ready_d     = 1'b1;
                        store_wr_en = lookup_hit;
                    end
                end
            end

            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end

            ST_WAIT: begin
                // On the first WAIT cycle (cnt_q == 0), mfc can still be the
                // stale high left over from the previous transaction.
                if ((cnt_q != '0) && bus_io.mem_mfc) begin
                    store_wr_en   = 1'b1;
                    store_wr_addr = maddr_q;
                    store_wr_data = bus_io.mem_rdata;
                    ready_d       = 1'b1;
                    rdata_d       = bus_io.mem_rdata;
                    state_d       = ST_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_DRAIN;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus_io.cpu_rdata  = rdata_q;
    assign bus_io.cpu_ready  = ready_q;
    assign bus_io.cpu_err    = err_q;
    assign bus_io.cpu_busy   = busy_q;
    assign bus_io.mem_strobe = strobe_q;
    assign bus_io.mem_rnotw  = mrnotw_q;
    assign bus_io.mem_addr   = maddr_q;
    assign bus_io.mem_wdata  = mwdata_q;

`ifdef SLOWMEM_CACHE_STATS_EN
    logic        hit_evt;
    logic        miss_evt;
    logic        to_evt;
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
    logic [15:0] to_cnt_q;

    assign hit_evt  = (state_q == ST_IDLE) && bus_io.cpu_req && bus_io.cpu_rnotw && lookup_hit;
    assign miss_evt = (state_q == ST_WAIT) && ready_d && !err_d;
    assign to_evt   = (state_q == ST_WAIT) && err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            if (hit_evt && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (miss_evt && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
            if (to_evt && (to_cnt_q != 16'hFFFF)) begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count_o     = hit_cnt_q;
    assign miss_count_o    = miss_cnt_q;
    assign timeout_count_o = to_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_slowmem_cache_ctrl.sv
// ============================================================================
// Module      : tb_slowmem_cache_ctrl
// Description : Self-checking bench for slowmem_cache_ctrl.
//               - A slowmem model drops the stale mfc one cycle after a
//                 strobe and raises mfc MEMDELAY cycles after the strobe.
//               - A transaction-level model predicts the DUT outputs for
//                 every cycle.
//               - A compare process checks those predictions on every
//                 negedge.
//               - Directed steps then random traffic exercise the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slowmem_cache_ctrl;

    localparam int IDX_BITS = 3;
    localparam int TIMEOUT  = 32;
    localparam int DRAIN    = 6;
    localparam int MDLY     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    slowmem_cache_ctrl_if bus ();

    slowmem_cache_ctrl #(
        .IDX_BITS (IDX_BITS),
        .TIMEOUT  (TIMEOUT),
        .DRAIN    (DRAIN)
    ) dut (
        .clk    (clk),
        .reset  (rst),
        .bus_io (bus)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req_v, $time);
        end
    endfunction

    // ---------------- processor-side drive ----------------
    logic        req_r   = 1'b0;
    logic        rnotw_r = 1'b1;
    logic [15:0] addr_r  = 16'h0000;
    logic [15:0] wdata_r = 16'h0000;
    assign bus.cpu_req   = req_r;
    assign bus.cpu_rnotw = rnotw_r;
    assign bus.cpu_addr  = addr_r;
    assign bus.cpu_wdata = wdata_r;

    // ---------------- slowmem model ----------------
    logic [15:0] wmem [int];
    logic        mfc_r    = 1'b0;
    logic [15:0] mrd_r    = 16'h0000;
    int          m_cnt    = 0;
    logic [15:0] m_addr   = 16'h0000;
    bit          mem_dead = 1'b0;
    assign bus.mem_mfc   = mfc_r;
    assign bus.mem_rdata = mrd_r;

    function automatic logic [15:0] base_word(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hBEEF;
            16'h0018: return 16'hC0DE;
            16'h0020: return 16'h5A5A;
            default:  return (a * 16'd40503) ^ 16'h1357;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.mem_strobe === 1'b1) begin
            if (!bus.mem_rnotw) wmem[int'(bus.mem_addr)] = bus.mem_wdata;
            m_cnt  <= MDLY;
            m_addr <= bus.mem_addr;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == MDLY) mfc_r <= 1'b0;
            if (m_cnt == 1) begin
                mfc_r <= !mem_dead;
                mrd_r <= wmem.exists(int'(m_addr)) ? wmem[int'(m_addr)] : base_word(m_addr);
            end
        end
    end

    // ---------------- behavioural reference model ----------------
    bit          c_val [8];
    logic [12:0] c_tag [8];
    logic [15:0] c_dat [8];
    int          cyc, idle_at, miss_e, ix;
    bit          miss_on, hit, model_live = 1'b0;
    logic [15:0] miss_addr;
    bit          e_ready, e_err, e_strobe, e_rnotw, e_busy;
    logic [15:0] e_rdata, e_addr, e_wdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; idle_at = DRAIN; miss_on = 1'b0;
            for (int i = 0; i < 8; i++) c_val[i] = 1'b0;
            e_ready = 1'b0; e_err = 1'b0; e_strobe = 1'b0; e_busy = 1'b1;
            model_live = 1'b1;
        end else begin
            cyc++;
            e_ready = 1'b0; e_err = 1'b0; e_strobe = 1'b0;
            if (miss_on) begin
                if (cyc >= miss_e + 3 && bus.mem_mfc === 1'b1) begin
                    ix = int'(miss_addr[IDX_BITS-1:0]);
                    c_val[ix] = 1'b1; c_tag[ix] = miss_addr[15:IDX_BITS]; c_dat[ix] = bus.mem_rdata;
                    e_ready = 1'b1; e_rdata = bus.mem_rdata; idle_at = cyc; miss_on = 1'b0;
                end else if (cyc == miss_e + 1 + TIMEOUT) begin
                    e_ready = 1'b1; e_err = 1'b1; e_rdata = 16'h0000;
                    idle_at = cyc + DRAIN; miss_on = 1'b0;
                end
            end else if (cyc - 1 >= idle_at && req_r) begin
                ix  = int'(addr_r[IDX_BITS-1:0]);
                hit = c_val[ix] && (c_tag[ix] == addr_r[15:IDX_BITS]);
                if (rnotw_r) begin
                    if (hit) begin
                        e_ready = 1'b1; e_rdata = c_dat[ix];
                    end else begin
                        e_strobe = 1'b1; e_rnotw = 1'b1; e_addr = addr_r;
                        miss_on = 1'b1; miss_e = cyc; miss_addr = addr_r; idle_at = 1 << 30;
                    end
                end else begin
                    e_strobe = 1'b1; e_rnotw = 1'b0; e_addr = addr_r; e_wdata = wdata_r;
                    e_ready = 1'b1;
                    if (hit) c_dat[ix] = wdata_r;
                end
            end
            e_busy = (cyc < idle_at);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_live) begin
            chk("busy",   {31'd0, bus.cpu_busy},   {31'd0, e_busy});
            chk("ready",  {31'd0, bus.cpu_ready},  {31'd0, e_ready});
            chk("err",    {31'd0, bus.cpu_err},    {31'd0, e_err});
            chk("strobe", {31'd0, bus.mem_strobe}, {31'd0, e_strobe});
            if (e_ready) chk("rdata", {16'd0, bus.cpu_rdata}, {16'd0, e_rdata});
            if (e_strobe) begin
                chk("mem_rnotw", {31'd0, bus.mem_rnotw}, {31'd0, e_rnotw});
                chk("mem_addr",  {16'd0, bus.mem_addr},  {16'd0, e_addr});
                if (!e_rnotw) chk("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, e_wdata});
            end
            if (rst) begin
                chk("rst_rdata", {16'd0, bus.cpu_rdata}, 32'h0);
                chk("rst_rnotw", {31'd0, bus.mem_rnotw}, 32'h1);
                chk("rst_addr",  {16'd0, bus.mem_addr},  32'h0);
                chk("rst_wdata", {16'd0, bus.mem_wdata}, 32'h0);
            end
        end
    end

    // ---------------- directed request helper ----------------
    // Called at a negedge. stb and lat count negedges after the request was
    // driven (1 = the cycle right after the accepting edge).
    task automatic do_req(input bit rd, input logic [15:0] a, input logic [15:0] wd,
                          output logic [15:0] rdata, output bit err,
                          output int lat, output int stb);
        int n;
        n = 0;
        while (bus.cpu_busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL busy_wait cpu_busy stuck high, required 0");
        end
        rnotw_r = rd; addr_r = a; wdata_r = wd; req_r = 1'b1;
        lat = 0; stb = -1; rdata = 16'h0000; err = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            req_r = 1'b0;
            if (bus.mem_strobe === 1'b1 && stb < 0) stb = k;
            if (bus.cpu_ready === 1'b1) begin
                lat = k; rdata = bus.cpu_rdata; err = bus.cpu_err;
                break;
            end
        end
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL ready_wait no cpu_ready within 100 cycles, required one");
        end
    endtask

    logic [15:0] rd_v;
    bit          er_v;
    int          lat_v, stb_v, nb;

    initial begin
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // cold read miss
        do_req(1'b1, 16'h0010, 16'h0, rd_v, er_v, lat_v, stb_v);
        chk("miss_data",    {16'd0, rd_v}, 32'hBEEF);
        chk("miss_err",     {31'd0, er_v}, 32'h0);
        chk("miss_strobe",  stb_v, 32'd1);
        chk("miss_latency", lat_v - stb_v, 32'd6);

        // read hit
        do_req(1'b1, 16'h0010, 16'h0, rd_v, er_v, lat_v, stb_v);
        chk("hit_data",      {16'd0, rd_v}, 32'hBEEF);
        chk("hit_latency",   lat_v, 32'd1);
        chk("hit_no_strobe", stb_v, 32'hFFFF_FFFF);

        // write hit, then read back
        do_req(1'b0, 16'h0010, 16'h1234, rd_v, er_v, lat_v, stb_v);
        chk("wr_latency", lat_v, 32'd1);
        chk("wr_strobe",  stb_v, 32'd1);
        do_req(1'b1, 16'h0010, 16'h0, rd_v, er_v, lat_v, stb_v);
        chk("wr_hit_data",   {16'd0, rd_v}, 32'h1234);
        chk("wr_hit_nostrb", stb_v, 32'hFFFF_FFFF);

        // index alias: 0x0018 evicts 0x0010
        do_req(1'b1, 16'h0018, 16'h0, rd_v, er_v, lat_v, stb_v);
        chk("alias_data",   {16'd0, rd_v}, 32'hC0DE);
        chk("alias_strobe", stb_v, 32'd1);
        do_req(1'b1, 16'h0010, 16'h0, rd_v, er_v, lat_v, stb_v);
        chk("evict_strobe", stb_v, 32'd1);
        chk("evict_data",   {16'd0, rd_v}, 32'h1234);

        // write miss to a valid line with another tag leaves the line alone
        do_req(1'b0, 16'h0018, 16'h7777, rd_v, er_v, lat_v, stb_v);
        do_req(1'b1, 16'h0010, 16'h0, rd_v, er_v, lat_v, stb_v);
        chk("noalloc_hit",  lat_v, 32'd1);
        chk("noalloc_data", {16'd0, rd_v}, 32'h1234);
        do_req(1'b1, 16'h0018, 16'h0, rd_v, er_v, lat_v, stb_v);
        chk("wt_data", {16'd0, rd_v}, 32'h7777);

        // timeout: no mfc at all
        mem_dead = 1'b1;
        do_req(1'b1, 16'h0020, 16'h0, rd_v, er_v, lat_v, stb_v);
        chk("to_err",     {31'd0, er_v}, 32'h1);
        chk("to_data",    {16'd0, rd_v}, 32'h0);
        chk("to_latency", lat_v, 32'd34);
        nb = 0;
        while (bus.cpu_busy === 1'b1 && nb < 50) begin
            nb++;
            @(negedge clk);
        end
        chk("to_drain_busy", nb, 32'd6);
        mem_dead = 1'b0;
        do_req(1'b1, 16'h0020, 16'h0, rd_v, er_v, lat_v, stb_v);
        chk("to_nofill_strobe", stb_v, 32'd1);
        chk("to_refill_data",   {16'd0, rd_v}, 32'h5A5A);

        // reset two cycles into WAIT
        rnotw_r = 1'b1; addr_r = 16'h0030; req_r = 1'b1;
        @(negedge clk);
        req_r = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        do_req(1'b1, 16'h0018, 16'h0, rd_v, er_v, lat_v, stb_v);
        chk("rst_new_data",    {16'd0, rd_v}, 32'h7777);
        chk("rst_new_latency", lat_v - stb_v, 32'd6);
        do_req(1'b1, 16'h0020, 16'h0, rd_v, er_v, lat_v, stb_v);
        chk("rst_inval_strobe", stb_v, 32'd1);
        chk("rst_inval_data",   {16'd0, rd_v}, 32'h5A5A);

        // random traffic, including requests while busy and occasional timeouts
        for (int it = 0; it < 700; it++) begin
            @(negedge clk);
            req_r    = ($urandom_range(0, 9) < 4);
            rnotw_r  = ($urandom_range(0, 2) != 0);
            addr_r   = 16'(($urandom_range(0, 3) << 3) | $urandom_range(0, 7));
            wdata_r  = 16'($urandom);
            mem_dead = ($urandom_range(0, 9) == 0);
            if (it == 350) #2 rst = 1'b1;
            if (it == 352) #2 rst = 1'b0;
        end
        req_r = 1'b0;
        mem_dead = 1'b0;
        repeat (50) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slowmem_cache_ctrl.md
Name: slowmem_cache_ctrl

Overview:
- Processor-side initiator for the slowmem request/mfc protocol.
- Sits between the processor's load/store stage and slowmem, fronting it with a small direct-mapped, write-through, no-write-allocate cache.
- Converts single-cycle processor requests into slowmem strobe/rnotw transactions and returns a one-cycle completion pulse.

Parameters:
- IDX_BITS, 3: index width; LINES = 2**IDX_BITS one-word lines; tag = addr[15:IDX_BITS].
- TIMEOUT, 32: WAIT cycles without mfc before a read miss aborts.
- DRAIN, 6: cycles held busy after reset so a stale slowmem read (MEMDELAY+2) cannot be mistaken for a new one.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request valid; sampled only while cpu_busy=0.
- cpu_rnotw  in  1  1=read, 0=write.
- cpu_addr  in  16  word address.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  read data; valid only while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  pulses with cpu_ready on read timeout.
- cpu_busy  out  1  1 = request not accepted this cycle.
- mem_strobe  out  1  slowmem strobe; asserted exactly one cycle per transaction.
- mem_rnotw  out  1  slowmem rnotw.
- mem_addr  out  16  slowmem addr.
- mem_wdata  out  16  slowmem wdata.
- mem_mfc  in  1  slowmem memory-function-complete.
- mem_rdata  in  16  slowmem read data; valid while mem_mfc=1.

Behaviour:
- All outputs are registered.
- Reset (async) clears:
  - state to DRAIN
  - all valid bits
  - mem_strobe, cpu_ready, cpu_err to 0
  - cpu_rdata, mem_addr, mem_wdata to 0
  - mem_rnotw to 1
  - cpu_busy to 1
- States: DRAIN, IDLE, ISSUE, WAIT.
- DRAIN:
  - Counts DRAIN cycles with mem_mfc ignored, then enters IDLE.
  - cpu_busy=0 only in IDLE.
- IDLE with cpu_req=1 sampled at edge E:
  - Read hit (valid[idx] and tag match): the cycle after E has cpu_ready=1 and cpu_rdata=line data; stay IDLE; no mem traffic.
  - Read miss: the cycle after E has mem_strobe=1, mem_rnotw=1, mem_addr=cpu_addr; state goes ISSUE then WAIT; cpu_busy=1.
  - Write: the cycle after E has mem_strobe=1, mem_rnotw=0, mem_addr/mem_wdata driven, and cpu_ready=1.
    - On a hit, the line data is updated in the same edge.
    - On a miss, the line is untouched (no allocate).
    - Stay IDLE.
- Address and write data are latched at acceptance; cpu_* inputs are don't-care while busy. Requests made while cpu_busy=1 are dropped, not queued.
- WAIT:
  - mem_mfc is ignored on the first WAIT edge, because slowmem leaves a stale mfc=1 the cycle after a strobe.
  - From the second WAIT edge, mem_mfc=1 causes:
    - line[idx] <= mem_rdata, tag and valid set
    - next cycle cpu_ready=1, cpu_rdata=mem_rdata
    - state goes to IDLE.
- Timeout: TIMEOUT WAIT cycles without mfc cause cpu_ready=1, cpu_err=1, cpu_rdata=16'h0000; the line is not filled; state goes to DRAIN (flushes any late mfc).
- Latency with slowmem MEMDELAY=4:
  - read miss: cpu_ready 6 cycles after the mem_strobe cycle
  - read hit: 1 cycle
  - write: 1 cycle.
- A write to the index of a valid line with a different tag leaves the line unchanged.
- Index wrap: addresses 16'h0000 and 16'h0008 (IDX_BITS=3) map to the same line; a fill evicts silently (write-through, so there are no dirty lines).
- Reset mid-WAIT: the abort is immediate, the cache is invalidated, and DRAIN is entered.

Optional Feature:
- SLOWMEM_CACHE_STATS_EN defined:
  - Adds 16-bit saturating outputs hit_count, miss_count, timeout_count.
  - Each counts once per completed read of that type; all clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include holds: `WORD width; state encodings (DRAIN/IDLE/ISSUE/WAIT); MEMDELAY; derived default DRAIN = MEMDELAY+2.
- One sub-module, cache_line_store:
  - LINES x {valid, tag, data}
  - async-clear valid bits
  - one combinational read port (hit, data)
  - one synchronous write port (fill or write-hit update).
- FSM and protocol logic stay in slowmem_cache_ctrl.

Test Plan:
- Reset, then read 16'h0010 (mem holds 16'hBEEF) -> one mem_strobe with rnotw=1; cpu_ready and cpu_rdata=16'hBEEF 6 cycles after the strobe; cpu_err=0.
- Repeat read 16'h0010 -> cpu_ready next cycle with 16'hBEEF; mem_strobe stays 0.
- Write 16'h1234 to 16'h0010, then read 16'h0010 -> write strobe with rnotw=0 and cpu_ready in the same cycle; the read hits with 16'h1234 and no read strobe.
- Read 16'h0018 after 16'h0010 is cached -> miss and fill; a subsequent read of 16'h0010 misses again (eviction).
- Hold mem_mfc=0 during a miss -> after 32 WAIT cycles, cpu_ready=1, cpu_err=1, cpu_rdata=0; cpu_busy=1 for 6 drain cycles.
- Assert reset 2 cycles into WAIT, then issue a new read miss -> the old slowmem mfc is ignored; the new read returns correct data; a previously cached address now misses.
